decimal_to_flp_seq: RTL

//  Encoder half of the FLP<->decimal path: packs an unsigned fixed-point magnitude (integer part + binary

---
 rtl/decimal_to_flp_seq.sv | 71 +++++++
 1 files changed

// File: rtl/decimal_to_flp_seq.sv
// decimal_to_flp_seq: packs sign + unsigned fixed-point magnitude into an IEEE-754 single via bit-serial normalise and RNE rounding
module decimal_to_flp_seq #(
   parameter int INT_W  = 24,
   parameter int FRAC_W = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              sign_in,
   input  logic [INT_W-1:0]  int_in,
   input  logic [FRAC_W-1:0] frac_in,
   output logic              busy,
   output logic              done,
   output logic [31:0]       flp_out
);
   localparam int N = INT_W + FRAC_W;
   localparam logic [1:0] IDLE = 2'd0, NORM = 2'd1, ROUND = 2'd2, DONE = 2'd3;
   localparam logic [7:0] E_BASE = 8'(126 + INT_W);
   // every bit below the guard position feeds sticky
   localparam logic [N-1:0] LOW = {N{1'b1}} >> 25;
   logic [1:0]   state;
   logic [N-1:0] m;
   logic         sgn;
   logic [7:0]   s;
   logic [22:0]  mant;
   logic         guard, sticky, rnd;
   logic [23:0]  mant_r;
   logic [7:0]   e;
   always_comb begin
      mant   = m[N-2 -: 23];
      guard  = m[N-25];
      sticky = |(m & LOW);
      rnd    = guard & (sticky | mant[0]);
      mant_r = {1'b0, mant} + 24'(rnd);
      e      = E_BASE - s + 8'(mant_r[23]);
   end
   assign busy = state != IDLE;
   assign done = state == DONE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         m       <= '0;
         sgn     <= 1'b0;
         s       <= '0;
         flp_out <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               m     <= {int_in, frac_in};
               sgn   <= sign_in;
               s     <= '0;
               state <= NORM;
            end
            NORM: if (m == '0) begin
               flp_out <= '0;
               state   <= DONE;
            end else if (m[N-1]) begin
               state <= ROUND;
            end else begin
               m <= m << 1;
               s <= s + 8'd1;
            end
            ROUND: begin
               flp_out <= {sgn, e, mant_r[22:0]};
               state   <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
